instruction_fetch_stage: RTL and testbench

Front stage of the five-stage ARM pipeline. It owns the program counter and issues fetches to instruction memory over a request/ready handshake, so variable-latency memory is tolerated. It registers each fetched word with its PC+4 into the IF/ID pipeline register that feeds the decode stage. It also honours the hazard freeze from decode and branch redirects resolved in execute.

---
 rtl/instruction_fetch_stage_pkg.sv | 24 ++
 rtl/instruction_fetch_stage_if_id_register.sv | 34 +++
 rtl/instruction_fetch_stage.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared front-end pipeline definitions: fetch FSM encoding, PC step,
// default bubble word and the IF/ID payload layout.
package instruction_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] PC_INC      = 32'd4;
    localparam logic [XLEN-1:0] BUBBLE_WORD = 32'h0000_0000;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register with flush > freeze > load > bubble priority.
// Ports: clk, rst (sync active-low), flush, freeze, load, din (next slot),
//        dout (registered slot contents).
module if_id_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE = BUBBLE_WORD
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   freeze,
    input  logic   load,
    input  if_id_t din,
    output if_id_t dout
);

    localparam if_id_t EMPTY_SLOT = '{pc: '0, instruction: BUBBLE, valid: 1'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= EMPTY_SLOT;
        end else if (flush) begin
            dout <= EMPTY_SLOT;
        end else if (freeze) begin
            dout <= dout;
        end else if (load) begin
            dout <= din;
        end else begin
            dout <= EMPTY_SLOT;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake,
// and fills the IF/ID register while honouring freeze and branch redirects.
// Ports: clk, rst (sync active-low), FREEZE, BRANCH_TAKEN, BRANCH_ADDR,
//        IMEM_REQ/IMEM_ADDR/IMEM_READY/IMEM_RDATA (instruction memory),
//        PC/INSTRUCTION/VALID (IF/ID outputs).
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] BUBBLE   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FREEZE,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] BRANCH_ADDR,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_READY,
    input  logic [XLEN-1:0] IMEM_RDATA,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] INSTRUCTION,
    output logic            VALID
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tgt_q;
    logic [XLEN-1:0] hold_q;

    logic [XLEN-1:0] pc_next_c;
    logic            load_c;
    logic [XLEN-1:0] word_c;
    if_id_t          slot_in;
    if_id_t          slot_q;

    assign pc_next_c = pc_q + PC_INC;

    // Request is dropped immediately while reset is held, abandoning any
    // outstanding transaction; the address is the registered fetch pointer.
    assign IMEM_REQ  = rst && (state_q != S_HOLD);
    assign IMEM_ADDR = pc_q;

    // A fresh instruction is available for IF/ID
    always_comb begin
        load_c = 1'b0;
        word_c = hold_q;
        case (state_q)
            S_REQ: begin
                if (IMEM_READY && !BRANCH_TAKEN && !FREEZE) begin
                    load_c = 1'b1;
                    word_c = IMEM_RDATA;
                end
            end
            S_HOLD: begin
                if (!BRANCH_TAKEN && !FREEZE) begin
                    load_c = 1'b1;
                end
            end
            default: begin
                load_c = 1'b0;
            end
        endcase
    end

    // Fetch FSM and fetch pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (IMEM_READY) begin
                        if (BRANCH_TAKEN) begin
                            pc_q <= BRANCH_ADDR;
                        end else if (FREEZE) begin
                            hold_q  <= IMEM_RDATA;
                            state_q <= S_HOLD;
                        end else begin
                            pc_q <= pc_next_c;
                        end
                    end else if (BRANCH_TAKEN) begin
                        // Keep the address stable until memory accepts it
                        tgt_q   <= BRANCH_ADDR;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (IMEM_READY) begin
                        pc_q    <= BRANCH_TAKEN ? BRANCH_ADDR : tgt_q;
                        state_q <= S_REQ;
                    end else if (BRANCH_TAKEN) begin
                        tgt_q <= BRANCH_ADDR;
                    end
                end
                S_HOLD: begin
                    if (BRANCH_TAKEN) begin
                        pc_q    <= BRANCH_ADDR;
                        state_q <= S_REQ;
                    end else if (!FREEZE) begin
                        pc_q    <= pc_next_c;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    assign slot_in = '{pc: pc_next_c, instruction: word_c, valid: 1'b1};

    if_id_register #(
        .BUBBLE (BUBBLE)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .flush  (BRANCH_TAKEN),
        .freeze (FREEZE),
        .load   (load_c),
        .din    (slot_in),
        .dout   (slot_q)
    );

    assign PC          = slot_q.pc;
    assign INSTRUCTION = slot_q.instruction;
    assign VALID       = slot_q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a queue of expected IF/ID
// loads; memory returns addr ^ 32'hA5A5_0000.
module tb_instruction_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam int MODE_BUB  = 0;
    localparam int MODE_LOAD = 1;
    localparam int MODE_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] exp_q[$];
    logic [31:0] last_pc  = 32'h0;
    logic [31:0] last_ins = 32'h0;
    logic        last_vld = 1'b0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ KEY;

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .BUBBLE   (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .FREEZE       (freeze),
        .BRANCH_TAKEN (branch_taken),
        .BRANCH_ADDR  (branch_addr),
        .IMEM_REQ     (imem_req),
        .IMEM_ADDR    (imem_addr),
        .IMEM_READY   (imem_ready),
        .IMEM_RDATA   (imem_rdata),
        .PC           (pc),
        .INSTRUCTION  (instruction),
        .VALID        (valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the IF/ID slot against bubble, the next queued load, or the held slot
    task automatic chk_slot(input string tag, input int mode);
        logic [63:0] e;
        if (mode == MODE_LOAD) begin
            if (exp_q.size() == 0) begin
                chk({tag, " queue"}, 32'd0, 32'd1);
                return;
            end
            e = exp_q.pop_front();
            last_pc  = e[63:32];
            last_ins = e[31:0];
            last_vld = 1'b1;
        end else if (mode == MODE_BUB) begin
            last_pc  = 32'h0;
            last_ins = 32'h0;
            last_vld = 1'b0;
        end
        chk({tag, " valid"}, 32'(valid), 32'(last_vld));
        chk({tag, " pc"}, pc, last_pc);
        chk({tag, " instr"}, instruction, last_ins);
    endtask

    // One cycle: drive inputs, check request side, clock, check IF/ID slot
    task automatic cyc(input string tag, input logic rdy, input logic fz, input logic bt,
                       input logic [31:0] ba, input logic exp_req, input logic [31:0] exp_addr,
                       input int mode, input logic [31:0] ld_pc, input logic [31:0] ld_ins);
        imem_ready   = rdy;
        freeze       = fz;
        branch_taken = bt;
        branch_addr  = ba;
        #1;
        chk({tag, " req"}, 32'(imem_req), 32'(exp_req));
        if (exp_req) chk({tag, " addr"}, imem_addr, exp_addr);
        if (mode == MODE_LOAD) exp_q.push_back({ld_pc, ld_ins});
        @(posedge clk);
        #1;
        chk_slot(tag, mode);
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset req", 32'(imem_req), 32'd0);
        chk_slot("reset", MODE_BUB);
        rst = 1'b1;

        // Zero-wait streaming
        cyc("f0", 1, 0, 0, 0, 1, 32'd0, MODE_LOAD, 32'd4, 32'd0 ^ KEY);
        cyc("f4", 1, 0, 0, 0, 1, 32'd4, MODE_LOAD, 32'd8, 32'd4 ^ KEY);
        // Two wait cycles at address 8
        cyc("w8a", 0, 0, 0, 0, 1, 32'd8, MODE_BUB, 0, 0);
        cyc("w8b", 0, 0, 0, 0, 1, 32'd8, MODE_BUB, 0, 0);
        cyc("f8", 1, 0, 0, 0, 1, 32'd8, MODE_LOAD, 32'd12, 32'd8 ^ KEY);
        // Freeze for three cycles while fetch 12 completes
        cyc("fz1", 1, 1, 0, 0, 1, 32'd12, MODE_HOLD, 0, 0);
        cyc("fz2", 1, 1, 0, 0, 0, 32'd0, MODE_HOLD, 0, 0);
        cyc("fz3", 1, 1, 0, 0, 0, 32'd0, MODE_HOLD, 0, 0);
        cyc("rel", 1, 0, 0, 0, 0, 32'd0, MODE_LOAD, 32'd16, 32'd12 ^ KEY);
        cyc("f16", 1, 0, 0, 0, 1, 32'd16, MODE_LOAD, 32'd20, 32'd16 ^ KEY);
        // Branch to 0x100 while fetch at 20 waits
        cyc("br1", 0, 0, 1, 32'h100, 1, 32'd20, MODE_BUB, 0, 0);
        cyc("dr1", 0, 0, 0, 0, 1, 32'd20, MODE_BUB, 0, 0);
        cyc("dr2", 1, 0, 0, 0, 1, 32'd20, MODE_BUB, 0, 0);
        cyc("t100", 1, 0, 0, 0, 1, 32'h100, MODE_LOAD, 32'h104, 32'h100 ^ KEY);
        // Freeze and branch together: branch wins
        cyc("fzbr", 1, 1, 1, 32'h200, 1, 32'h104, MODE_BUB, 0, 0);
        cyc("t200", 1, 0, 0, 0, 1, 32'h200, MODE_LOAD, 32'h204, 32'h200 ^ KEY);
        // Wrap-around of the fetch pointer
        cyc("brw", 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h204, MODE_BUB, 0, 0);
        cyc("ftop", 1, 0, 0, 0, 1, 32'hFFFF_FFFC, MODE_LOAD, 32'h0, 32'hFFFF_FFFC ^ KEY);
        cyc("fwrap", 1, 0, 0, 0, 1, 32'h0, MODE_LOAD, 32'h4, 32'h0 ^ KEY);
        // Newest redirect wins during drain
        cyc("d1", 0, 0, 1, 32'h300, 1, 32'h4, MODE_BUB, 0, 0);
        cyc("d2", 0, 0, 1, 32'h400, 1, 32'h4, MODE_BUB, 0, 0);
        cyc("d3", 1, 0, 0, 0, 1, 32'h4, MODE_BUB, 0, 0);
        cyc("t400", 1, 0, 0, 0, 1, 32'h400, MODE_LOAD, 32'h404, 32'h400 ^ KEY);
        // Branch out of the hold state
        cyc("hz1", 1, 1, 0, 0, 1, 32'h404, MODE_HOLD, 0, 0);
        cyc("hbr", 1, 0, 1, 32'h600, 0, 32'h0, MODE_BUB, 0, 0);
        cyc("t600", 1, 0, 0, 0, 1, 32'h600, MODE_LOAD, 32'h604, 32'h600 ^ KEY);
        // Reset in the middle of a drain
        cyc("d5", 0, 0, 1, 32'h500, 1, 32'h604, MODE_BUB, 0, 0);
        rst = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
        #1;
        chk("rst req low", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        chk("rst req", 32'(imem_req), 32'd0);
        chk_slot("rst mid", MODE_BUB);
        rst = 1'b1;
        cyc("rf0", 1, 0, 0, 0, 1, 32'd0, MODE_LOAD, 32'd4, 32'd0 ^ KEY);
        chk("queue empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
